// File: rtl/forwarding_unit.sv
// Purpose: operand-forwarding selects and hazard stall for the EXE stage, tracking write metadata for EXE/MEM/WB.
// Latency: selects and hazard_stall are combinational; the EXE/MEM/WB slots advance on every clock edge.
// Backpressure: hazard_stall freezes PC and IF/ID and puts a bubble into EXE; flush overrides the stall.
module forwarding_unit #(
  parameter int REG_ADDR_LEN   = 4,
  parameter int FORW_SEL_LEN   = 2,
  parameter int CNT_LEN        = 16,
  parameter int ZERO_REG_FIXED = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forward_en,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic [REG_ADDR_LEN-1:0] id_st_src,
  input  logic                    id_use_src2,
  input  logic                    id_is_store,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    flush,
  output logic [FORW_SEL_LEN-1:0] val1_sel,
  output logic [FORW_SEL_LEN-1:0] val2_sel,
  output logic [FORW_SEL_LEN-1:0] ST_val_sel,
  output logic                    hazard_stall,
  output logic [CNT_LEN-1:0]      stall_count
);

  localparam logic [FORW_SEL_LEN-1:0] SEL_OWN = FORW_SEL_LEN'(0);
  localparam logic [FORW_SEL_LEN-1:0] SEL_MEM = FORW_SEL_LEN'(1);
  localparam logic [FORW_SEL_LEN-1:0] SEL_WB  = FORW_SEL_LEN'(2);

  // EXE slot
  logic [REG_ADDR_LEN-1:0] r_exe_src1, r_exe_src2, r_exe_st_src, r_exe_dest;
  logic                    r_exe_use_src2, r_exe_is_store, r_exe_wb_en, r_exe_mem_r_en;
  // MEM slot
  logic [REG_ADDR_LEN-1:0] r_mem_dest;
  logic                    r_mem_wb_en, r_mem_mem_r_en;
  // WB slot
  logic [REG_ADDR_LEN-1:0] r_wb_dest;
  logic                    r_wb_wb_en;

  logic [CNT_LEN-1:0]      r_cnt;
  logic                    w_bubble;
  logic                    w_mem_fwd_en;
  logic                    w_id_hit_exe, w_id_hit_mem, w_id_hit_wb;

  // A slot matches a source when it writes that register; r0 is never a match when hard-wired.
  function automatic logic f_match(input logic wb_en, input logic [REG_ADDR_LEN-1:0] dest,
                                   input logic [REG_ADDR_LEN-1:0] src);
    return wb_en && (dest == src) && !((ZERO_REG_FIXED != 0) && (src == '0));
  endfunction

  // Youngest producer wins: MEM ahead of WB.
  function automatic logic [FORW_SEL_LEN-1:0] f_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem) return SEL_MEM;
    if (hit_wb)  return SEL_WB;
    return SEL_OWN;
  endfunction

  // Load data is not available in MEM, so a load there is never a forwarding source.
  assign w_mem_fwd_en = r_mem_wb_en && !r_mem_mem_r_en;

  // Operand selects from registered slot state only.
  always_comb begin
    val1_sel   = SEL_OWN;
    val2_sel   = SEL_OWN;
    ST_val_sel = SEL_OWN;
    if (forward_en) begin
      val1_sel = f_sel(f_match(w_mem_fwd_en, r_mem_dest, r_exe_src1),
                       f_match(r_wb_wb_en, r_wb_dest, r_exe_src1));
      if (r_exe_use_src2)
        val2_sel = f_sel(f_match(w_mem_fwd_en, r_mem_dest, r_exe_src2),
                         f_match(r_wb_wb_en, r_wb_dest, r_exe_src2));
      if (r_exe_is_store)
        ST_val_sel = f_sel(f_match(w_mem_fwd_en, r_mem_dest, r_exe_st_src),
                           f_match(r_wb_wb_en, r_wb_dest, r_exe_st_src));
    end
  end

  // Does any source read by the ID instruction match each slot.
  always_comb begin
    w_id_hit_exe = f_match(r_exe_wb_en, r_exe_dest, id_src1)
                || (id_use_src2 && f_match(r_exe_wb_en, r_exe_dest, id_src2))
                || (id_is_store && f_match(r_exe_wb_en, r_exe_dest, id_st_src));
    w_id_hit_mem = f_match(r_mem_wb_en, r_mem_dest, id_src1)
                || (id_use_src2 && f_match(r_mem_wb_en, r_mem_dest, id_src2))
                || (id_is_store && f_match(r_mem_wb_en, r_mem_dest, id_st_src));
    w_id_hit_wb  = f_match(r_wb_wb_en, r_wb_dest, id_src1)
                || (id_use_src2 && f_match(r_wb_wb_en, r_wb_dest, id_src2))
                || (id_is_store && f_match(r_wb_wb_en, r_wb_dest, id_st_src));
  end

  // Load-use stall with forwarding; full interlock without. A squashed instruction never stalls.
  always_comb begin
    hazard_stall = 1'b0;
    if (!flush) begin
      if (forward_en) hazard_stall = r_exe_mem_r_en && w_id_hit_exe;
      else            hazard_stall = w_id_hit_exe || w_id_hit_mem || w_id_hit_wb;
    end
  end

  assign w_bubble    = hazard_stall || flush;
  assign stall_count = r_cnt;

  // Advance the shadow pipeline; EXE takes a bubble on stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe_src1     <= '0;
      r_exe_src2     <= '0;
      r_exe_st_src   <= '0;
      r_exe_dest     <= '0;
      r_exe_use_src2 <= 1'b0;
      r_exe_is_store <= 1'b0;
      r_exe_wb_en    <= 1'b0;
      r_exe_mem_r_en <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_wb_en    <= 1'b0;
      r_mem_mem_r_en <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_wb_en     <= 1'b0;
    end else begin
      r_wb_dest      <= r_mem_dest;
      r_wb_wb_en     <= r_mem_wb_en;
      r_mem_dest     <= r_exe_dest;
      r_mem_wb_en    <= r_exe_wb_en;
      r_mem_mem_r_en <= r_exe_mem_r_en;
      if (w_bubble) begin
        r_exe_src1     <= '0;
        r_exe_src2     <= '0;
        r_exe_st_src   <= '0;
        r_exe_dest     <= '0;
        r_exe_use_src2 <= 1'b0;
        r_exe_is_store <= 1'b0;
        r_exe_wb_en    <= 1'b0;
        r_exe_mem_r_en <= 1'b0;
      end else begin
        r_exe_src1     <= id_src1;
        r_exe_src2     <= id_src2;
        r_exe_st_src   <= id_st_src;
        r_exe_dest     <= id_dest;
        r_exe_use_src2 <= id_use_src2;
        r_exe_is_store <= id_is_store;
        r_exe_wb_en    <= id_wb_en;
        r_exe_mem_r_en <= id_mem_r_en;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_cnt <= '0;
    else if (hazard_stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Producer side of the execute-stage operand-select interface: generates val1_sel, val2_sel and ST_val_sel for the instruction in EXE, plus the hazard stall toward IF/ID.
- Keeps its own shadow pipeline of register-write metadata across the EXE, MEM and WB slots.
- Detects load-use hazards, inserts bubbles, and provides full interlocking when forwarding is disabled.
- Sits beside the ID/EXE pipeline register and is driven by decode outputs.

Parameters:
- REG_ADDR_LEN, 4, width of register-file addresses.
- FORW_SEL_LEN, 2, width of each select output. Encodings: 0 = own operand, 1 = ALU_res_MEM, 2 = result_WB.
- CNT_LEN, 16, width of the saturating stall counter.
- ZERO_REG_FIXED, 1, when 1, register 0 never matches for forwarding or hazards.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- forward_en  in  1  1 = forwarding on, 0 = interlock-only mode
- id_src1  in  REG_ADDR_LEN  ID first source register
- id_src2  in  REG_ADDR_LEN  ID second source register
- id_st_src  in  REG_ADDR_LEN  ID store-data source register
- id_use_src2  in  1  ID instruction reads src2
- id_is_store  in  1  ID instruction is a store
- id_dest  in  REG_ADDR_LEN  ID destination register
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- flush  in  1  branch taken; squash the ID instruction
- val1_sel  out  FORW_SEL_LEN  EXE operand-1 select
- val2_sel  out  FORW_SEL_LEN  EXE operand-2 select
- ST_val_sel  out  FORW_SEL_LEN  EXE store-value select
- hazard_stall  out  1  freeze PC and IF/ID; bubble into EXE
- stall_count  out  CNT_LEN  number of cycles with hazard_stall=1, saturating

Behaviour:
- State: the EXE slot holds {src1, src2, st_src, use_src2, is_store, dest, wb_en, mem_r_en}. The MEM slot holds {dest, wb_en, mem_r_en}. The WB slot holds {dest, wb_en}.
- Every rising edge: WB <= MEM and MEM <= EXE. EXE <= ID fields, or a bubble (all enables 0, addresses 0) when hazard_stall=1 or flush=1.
- Reset (rst=0, asynchronous): all slots become bubbles and stall_count=0. Consequently all selects=0 and hazard_stall=0 while reset is held and in the first cycle after release. Reset mid-stall discards the stall with no residue.
- Match rule: a slot matches source s when the slot's wb_en=1, its dest==s, and NOT (ZERO_REG_FIXED and s==0).
- Selects are combinational from registered state only; there is no ID-input path.
  - forward_en=1, val1_sel: 1 if MEM matches EXE.src1, else 2 if WB matches, else 0. MEM has priority over WB (youngest wins).
  - val2_sel: same rule applied to EXE.src2, gated by EXE.use_src2 (0 when not used).
  - ST_val_sel: same rule applied to EXE.st_src, gated by EXE.is_store.
  - forward_en=0: all selects=0.
- hazard_stall (combinational from ID inputs and slots). The ID sources considered are src1, src2 if id_use_src2, and st_src if id_is_store.
  - forward_en=1: stall=1 when the EXE slot has mem_r_en=1 and matches any considered ID source (load-use). The stall is exactly 1 cycle, because the load then advances to MEM and the next cycle it is forwarded from WB.
  - forward_en=0: stall=1 when any of the EXE, MEM or WB slots matches any considered ID source. This can hold for up to 3 consecutive cycles.
  - flush=1 forces hazard_stall=0 in that cycle. The squashed instruction must not stall.
- By construction, a load in MEM never matches the EXE sources while forward_en=1. The ALU_res_MEM select is never chosen for load data.
- stall_count increments on each clock with hazard_stall=1 and saturates at all-ones (no wrap).
- Simultaneous stall and flush: flush wins; the EXE slot gets a bubble and the counter does not increment.
- forward_en may change on any cycle. Its effect is immediate on the combinational outputs; slot contents are unaffected.

Test Plan:
- ADD r3 followed by SUB r4,r3,r1, forward_en=1 -> next cycle val1_sel=1, hazard_stall never asserted.
- ADD r3; NOP; ADD r5,r1,r3 -> val2_sel=2 for the consumer in EXE. With r3 written in both MEM and WB, the select is 1 (MEM priority).
- LDR r2 then ADD r6,r2,r2 -> hazard_stall=1 for exactly one cycle, stall_count 0->1. Consumer then gets val1_sel=2 and val2_sel=2.
- STR with data r7 immediately after ADD r7 -> ST_val_sel=1. Same sequence with id_is_store=0 -> ST_val_sel=0.
- forward_en=0, ADD r3 then a consumer of r3 -> hazard_stall=1 for 3 cycles, all selects 0, stall_count=3. Writes to r0 with ZERO_REG_FIXED=1 -> no stall and no forwarding.
- Load-use hazard present with flush=1 in the same cycle -> hazard_stall=0 and a bubble in EXE. Asserting rst=0 mid-sequence -> all outputs 0 immediately, and stall_count=0.
